aes_inv_round_unit: RTL and testbench

AES_INV_ROUND_UNIT -- requirements
Module: aes_inv_round_unit

---
 rtl/aes_inv_round_unit.sv | 141 ++++++++++++++
 tb/tb_aes_inv_round_unit.sv | 132 +++++++++++++
 2 files changed

// File: rtl/aes_inv_round_unit.sv
// One AES inverse-cipher round per cycle: ADDKEY_ONLY, FULL_ROUND or FINAL_ROUND into a registered state.
// Optional macro INV_SBOX_SEED_EN: InvSubBytes output is XORed with sbox_seed (inverse of Sbox(y ^ seed)).

module aes_inv_col (
    input  logic [31:0] col_i,
    input  logic [31:0] key_i,
    input  logic [7:0]  seed_i,
    output logic [31:0] final_o,
    output logic [31:0] full_o
);
    localparam logic [0:255][7:0] INV_SBOX = {
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One output byte of InvMixColumns: {0e,0b,0d,09} applied to a rotated column.
    function automatic logic [7:0] imix(input logic [7:0] a0, input logic [7:0] a1,
                                        input logic [7:0] a2, input logic [7:0] a3);
        logic [7:0] m0, m1, m2, m3;
        m0 = xt(xt(xt(a0))) ^ xt(xt(a0)) ^ xt(a0);
        m1 = xt(xt(xt(a1))) ^ xt(a1) ^ a1;
        m2 = xt(xt(xt(a2))) ^ xt(xt(a2)) ^ a2;
        m3 = xt(xt(xt(a3))) ^ a3;
        return m0 ^ m1 ^ m2 ^ m3;
    endfunction

    logic [0:3][7:0] sub;
    logic [0:3][7:0] ak;

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            sub[b] = INV_SBOX[col_i[31-8*b -: 8]] ^ seed_i;
        end
    end

    assign ak      = sub ^ key_i;
    assign final_o = ak;
    assign full_o  = {imix(ak[0], ak[1], ak[2], ak[3]), imix(ak[1], ak[2], ak[3], ak[0]),
                      imix(ak[2], ak[3], ak[0], ak[1]), imix(ak[3], ak[0], ak[1], ak[2])};
endmodule

module aes_inv_round_unit (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [1:0]   op,
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic [7:0]   sbox_seed,
    output logic         out_valid,
    output logic [127:0] state_out
);
    typedef enum logic [1:0] {
        OP_ADDKEY = 2'd0,
        OP_FULL   = 2'd1,
        OP_FINAL  = 2'd2,
        OP_RSVD   = 2'd3
    } op_e;

    op_e             op_sel;
    logic [7:0]      seed_eff;
    logic [127:0]    shifted;
    logic [0:3][31:0] final_st;
    logic [0:3][31:0] full_st;
    logic [127:0]    state_d, state_q;
    logic            valid_d, valid_q;

    assign op_sel = op_e'(op);

`ifdef INV_SBOX_SEED_EN
    assign seed_eff = sbox_seed;
`else
    logic unused_seed;
    assign unused_seed = ^sbox_seed;
    assign seed_eff    = 8'h00;
`endif

    // InvShiftRows: byte (row r, col c) comes from (row r, col c-r mod 4).
    always_comb begin
        shifted = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                shifted[127-8*(r+4*c) -: 8] = state_in[127-8*(r+4*((c+4-r)%4)) -: 8];
            end
        end
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        aes_inv_col u_col (
            .col_i   (shifted[127-32*c -: 32]),
            .key_i   (round_key[127-32*c -: 32]),
            .seed_i  (seed_eff),
            .final_o (final_st[c]),
            .full_o  (full_st[c])
        );
    end

    always_comb begin
        state_d = state_q;
        valid_d = 1'b0;
        if (in_valid) begin
            case (op_sel)
                OP_ADDKEY: begin state_d = state_in ^ round_key; valid_d = 1'b1; end
                OP_FULL:   begin state_d = full_st;              valid_d = 1'b1; end
                OP_FINAL:  begin state_d = final_st;             valid_d = 1'b1; end
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
        end
    end

    assign state_out = state_q;
    assign out_valid = valid_q;
endmodule

// File: tb/tb_aes_inv_round_unit.sv
// Scoreboard bench for aes_inv_round_unit: directed vectors push expected results, a monitor pops on out_valid.
module tb_aes_inv_round_unit;
    logic         clk = 1'b0;
    logic         rst_n, in_valid;
    logic [1:0]   op;
    logic [127:0] state_in, round_key;
    logic [7:0]   sbox_seed;
    logic         out_valid;
    logic [127:0] state_out;

    aes_inv_round_unit dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op(op),
        .state_in(state_in), .round_key(round_key), .sbox_seed(sbox_seed),
        .out_valid(out_valid), .state_out(state_out)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] FIPS_IN  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] FIPS_KEY = 128'h24fc79ccbf0979e9371ac23c6d68de36;
    localparam logic [127:0] FIPS_AK  = 128'haa5ece06ee6e3c56dde68bac2621bebf;
    localparam logic [127:0] IS_BOX   = 128'h627bceb9999d5aaac945ecf423f56da5;
    localparam logic [127:0] ALL52    = {16{8'h52}};
    // Known MixColumns columns: InvMixColumns(MIX_IN) = MIX_OUT.
    localparam logic [127:0] MIX_IN   = 128'h8e4da1bc9fdc589dd5d5d7d64d7ebdf8;
    localparam logic [127:0] MIX_OUT  = 128'hdb135345f20a225cd4d4d4d52d26314c;
`ifdef INV_SBOX_SEED_EN
    localparam logic [127:0] SEED_EXP = {16{8'hf7}};
`else
    localparam logic [127:0] SEED_EXP = {16{8'h52}};
`endif

    typedef struct { logic [127:0] st; int due; } exp_t;
    exp_t         sb_q[$];
    int           total = 0;
    int           bad   = 0;
    int           cyc   = 0;
    logic         rst_seen = 1'b0;
    logic [127:0] hold = '0;

    initial forever begin
        @(posedge clk);
        cyc++;
        rst_seen = rst_n;
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        total++;
        if (!rst_seen) begin
            hold = '0;
            if (out_valid !== 1'b0 || state_out !== 128'h0) begin
                bad++;
                $display("FAIL reset: out_valid=%b state_out=%h want 0 and 0", out_valid, state_out);
            end
        end else if (out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL spurious: out_valid=1 state_out=%h at cycle %0d with nothing pending", state_out, cyc);
            end else begin
                e = sb_q.pop_front();
                hold = e.st;
                if (state_out !== e.st || cyc != e.due) begin
                    bad++;
                    $display("FAIL result: got %h at cycle %0d want %h at cycle %0d", state_out, cyc, e.st, e.due);
                end
            end
        end else begin
            if (out_valid !== 1'b0 || state_out !== hold) begin
                bad++;
                $display("FAIL hold: out_valid=%b state_out=%h want 0 and %h", out_valid, state_out, hold);
            end
        end
    end

    task automatic drive(input logic [1:0] o, input logic [127:0] s, input logic [127:0] k,
                         input logic [7:0] sd, input bit expect_out, input logic [127:0] e);
        exp_t x;
        in_valid = 1'b1; op = o; state_in = s; round_key = k; sbox_seed = sd;
        if (expect_out) begin
            x.st = e; x.due = cyc + 1;
            sb_q.push_back(x);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0; op = 2'd1; state_in = FIPS_IN; round_key = FIPS_KEY; sbox_seed = 8'h3c;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; op = 2'd0; state_in = FIPS_IN; round_key = FIPS_KEY; sbox_seed = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; in_valid = 1'b0;
        idle(3);

        // back-to-back stream, one result per cycle
        drive(2'd0, FIPS_IN, FIPS_KEY, 8'h00, 1'b1, FIPS_AK);
        drive(2'd2, '0, '0, 8'h00, 1'b1, ALL52);
        drive(2'd1, '0, '0, 8'h00, 1'b1, ALL52);
        drive(2'd2, FIPS_AK, '0, 8'h00, 1'b1, IS_BOX);
        drive(2'd1, FIPS_AK, IS_BOX ^ MIX_IN, 8'h00, 1'b1, MIX_OUT);
        idle(2);

        // reserved op must be ignored and the previous result held
        drive(2'd3, FIPS_IN, FIPS_KEY, 8'h00, 1'b0, '0);
        drive(2'd3, '0, '0, 8'h00, 1'b0, '0);
        idle(2);

        // reset coincident with a request discards it
        rst_n = 1'b0; in_valid = 1'b1; op = 2'd1; state_in = FIPS_AK; round_key = FIPS_KEY;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(3);

        drive(2'd2, '0, '0, 8'ha5, 1'b1, SEED_EXP);
        drive(2'd0, FIPS_IN, FIPS_KEY, 8'ha5, 1'b1, FIPS_AK);
        idle(4);

        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d results still pending, want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
